// File: rtl/instruction_fetch_if.sv
// Instruction fetch bus: the memory read channel, the redirect input from
// execute and the valid/ready hand-off to decode, bundled for one fetch unit.
interface instruction_fetch_if #(
  parameter int addrSize  = 32,
  parameter int dataWidth = 32
);
  logic                 imemReq;
  logic [addrSize-1:0]  imemAddr;
  logic                 imemValid;
  logic [dataWidth-1:0] imemData;
  logic                 redirect;
  logic [addrSize-1:0]  redirectPC;
  logic                 instValid;
  logic [dataWidth-1:0] instruction;
  logic [addrSize-1:0]  instPC;
  logic                 instReady;

  modport master (
    output imemReq, imemAddr, instValid, instruction, instPC,
    input  imemValid, imemData, redirect, redirectPC, instReady
  );

  modport slave (
    input  imemReq, imemAddr, instValid, instruction, instPC,
    output imemValid, imemData, redirect, redirectPC, instReady
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the program counter, streams sequential word
// fetches from instruction memory into a small PC-tagged FIFO and presents the
// head entry to decode. A redirect empties the FIFO, drops any outstanding
// fetch and restarts at the new PC after a one-cycle bubble.
module instruction_fetch #(
  parameter int                  addrSize  = 32,
  parameter int                  dataWidth = 32,
  parameter logic [addrSize-1:0] resetPC   = '0,
  parameter int                  pcStep    = 4,
  parameter int                  bufDepth  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  instruction_fetch_if.master  bus
);

  localparam int ptrW = (bufDepth > 1) ? $clog2(bufDepth) : 1;
  localparam int cntW = $clog2(bufDepth + 1);
  localparam logic [ptrW-1:0] lastIdx   = ptrW'(bufDepth - 1);
  localparam logic [cntW-1:0] fullCount = cntW'(bufDepth);

  typedef enum logic [1:0] {BOOT, FETCH, REDIR} stateType;

  stateType             state, nextState;
  logic [addrSize-1:0]  fetchPC;
  logic [cntW-1:0]      count, countNext;
  logic [ptrW-1:0]      rdPtr, wrPtr, rdPtrNext;
  logic [dataWidth-1:0] bufInst [bufDepth];
  logic [addrSize-1:0]  bufPC   [bufDepth];
  logic [dataWidth-1:0] headInst;
  logic [addrSize-1:0]  headPC;
  logic                 imemReq, hit, push, pop, pushToHead;

  // A hit that coincides with a redirect belongs to the abandoned path and is dropped.
  assign hit  = imemReq && bus.imemValid;
  assign push = hit && !bus.redirect;
  assign pop  = (count != '0) && bus.instReady;

  assign bus.imemReq     = imemReq;
  assign bus.imemAddr    = fetchPC;
  assign bus.instValid   = (count != '0);
  assign bus.instruction = headInst;
  assign bus.instPC      = headPC;

  // State register; reset parks the unit in BOOT for one bubble cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= nextState;
  end

  // Next state and request decode; requests only while the buffer has room, so a hit can never overflow it.
  always_comb begin
    nextState = FETCH;
    imemReq   = 1'b0;
    case (state)
      BOOT:    nextState = FETCH;
      FETCH: begin
        imemReq   = (count < fullCount);
        nextState = FETCH;
      end
      REDIR:   nextState = FETCH;
      default: nextState = BOOT;
    endcase
    if (bus.redirect) nextState = REDIR;
  end

  // Fetch PC advances only on an accepted hit; redirect overrides and wraps are left to modulo arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               fetchPC <= resetPC;
    else if (bus.redirect) fetchPC <= bus.redirectPC;
    else if (push)         fetchPC <= fetchPC + addrSize'(pcStep);
  end

  // Occupancy and read-pointer lookahead, plus whether this cycle's push lands directly at the head.
  always_comb begin
    rdPtrNext = rdPtr;
    if (pop) rdPtrNext = (rdPtr == lastIdx) ? '0 : rdPtr + ptrW'(1);
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + cntW'(1);
      2'b01:   countNext = count - cntW'(1);
      default: countNext = count;
    endcase
    pushToHead = push && ((count == '0) || ((count == cntW'(1)) && pop));
  end

  // FIFO storage; entries need no reset because occupancy gates their visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      bufInst[wrPtr] <= bus.imemData;
      bufPC[wrPtr]   <= fetchPC;
    end
  end

  // FIFO control and registered head; the head keeps its last value while the buffer is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      headInst <= '0;
      headPC   <= '0;
    end else if (bus.redirect) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      count <= countNext;
      rdPtr <= rdPtrNext;
      if (push) wrPtr <= (wrPtr == lastIdx) ? '0 : wrPtr + ptrW'(1);
      if (countNext != '0) begin
        if (pushToHead) begin
          headInst <= bus.imemData;
          headPC   <= fetchPC;
        end else begin
          headInst <= bufInst[rdPtrNext];
          headPC   <= bufPC[rdPtrNext];
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the instruction fetch unit: reset, streaming, decode
// backpressure, slow memory, redirect with a discarded hit, PC wrap and an
// asynchronous reset in the middle of a fetch.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_fetch_if #(.addrSize(32), .dataWidth(32)) bus ();

  instruction_fetch #(
    .addrSize(32), .dataWidth(32), .resetPC(32'h0), .pcStep(4), .bufDepth(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction word stored at each address of the modelled memory.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign bus.imemData = memWord(bus.imemAddr);

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then advance to 1 time unit past the next rising edge.
  task automatic applyStimulus(input logic valid, input logic ready,
                               input logic redir, input logic [31:0] rpc);
    bus.imemValid  = valid;
    bus.instReady  = ready;
    bus.redirect   = redir;
    bus.redirectPC = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Synchronous-looking reset pulse that leaves the DUT in its BOOT cycle.
  task automatic doReset();
    bus.imemValid  = 1'b0;
    bus.instReady  = 1'b0;
    bus.redirect   = 1'b0;
    bus.redirectPC = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.imemValid  = 1'b0;
    bus.instReady  = 1'b0;
    bus.redirect   = 1'b0;
    bus.redirectPC = '0;

    // Reset held, then BOOT bubble, then first request at address 0.
    @(posedge clk);
    #1;
    checkOutput("rstReq",   {31'b0, bus.imemReq},   32'd0);
    checkOutput("rstAddr",  bus.imemAddr,           32'd0);
    checkOutput("rstValid", {31'b0, bus.instValid}, 32'd0);
    rst = 1'b0;
    checkOutput("bootReq",  {31'b0, bus.imemReq},   32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fetchReq",  {31'b0, bus.imemReq}, 32'd1);
    checkOutput("fetchAddr", bus.imemAddr,         32'd0);

    // Zero-latency memory with decode always ready: one instruction per cycle.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("streamValid", {31'b0, bus.instValid}, 32'd1);
      checkOutput("streamPC",    bus.instPC,             32'(4 * k));
      checkOutput("streamInst",  bus.instruction,        memWord(32'(4 * k)));
    end

    // Decode stalls: two entries fill the buffer, requests stop, then resume after a pop.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bpPC0",    bus.instPC,           32'd0);
    checkOutput("bpReq1",   {31'b0, bus.imemReq}, 32'd1);
    checkOutput("bpAddr1",  bus.imemAddr,         32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bpFullReq",  {31'b0, bus.imemReq}, 32'd0);
    checkOutput("bpFullAddr", bus.imemAddr,         32'd8);
    checkOutput("bpFullPC",   bus.instPC,           32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("bpHoldReq",  {31'b0, bus.imemReq}, 32'd0);
    checkOutput("bpHoldPC",   bus.instPC,           32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("bpPopPC",    bus.instPC,           32'd4);
    checkOutput("bpPopReq",   {31'b0, bus.imemReq}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("bpNextPC",   bus.instPC,           32'd8);
    checkOutput("bpNextAddr", bus.imemAddr,         32'd12);

    // Three-cycle memory: address held for three cycles, one instruction per three cycles.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("latAddrA", bus.imemAddr, 32'(4 * k));
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("latAddrB", bus.imemAddr,           32'(4 * k));
      checkOutput("latEmpty", {31'b0, bus.instValid}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("latValid", {31'b0, bus.instValid}, 32'd1);
      checkOutput("latPC",    bus.instPC,             32'(4 * k));
      checkOutput("latAddrC", bus.imemAddr,           32'(4 * k + 4));
    end

    // Redirect with one buffered entry and a same-cycle hit that must be discarded.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redPre", {31'b0, bus.instValid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
    checkOutput("redValid", {31'b0, bus.instValid}, 32'd0);
    checkOutput("redReq",   {31'b0, bus.imemReq},   32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redReq2",  {31'b0, bus.imemReq},   32'd1);
    checkOutput("redAddr",  bus.imemAddr,           32'h100);
    checkOutput("redEmpty", {31'b0, bus.instValid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redPC",   bus.instPC,      32'h100);
    checkOutput("redInst", bus.instruction, memWord(32'h100));

    // Fetch at the top of the address space wraps to zero.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrapFlush", {31'b0, bus.instValid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapAddr0", bus.imemAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapAddr1", bus.imemAddr, 32'h0);
    checkOutput("wrapPC",    bus.instPC,   32'hFFFF_FFFC);

    // Asynchronous reset between edges must take effect immediately.
    bus.imemValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arstReq",   {31'b0, bus.imemReq},   32'd0);
    checkOutput("arstAddr",  bus.imemAddr,           32'd0);
    checkOutput("arstValid", {31'b0, bus.instValid}, 32'd0);
    checkOutput("arstInst",  bus.instruction,        32'd0);
    checkOutput("arstPC",    bus.instPC,             32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("arstBoot", {31'b0, bus.imemReq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
